jtcop_sndlatch_tx: RTL and testbench

//  Main-CPU side of the sound command channel: captures bytes written by the 68000 to the

---
 rtl/jtcop_sndlatch_tx.sv | 169 ++++++++++++++++
 tb/tb_jtcop_sndlatch_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_sndlatch_tx.sv
// jtcop_sndlatch_tx: main-CPU side of the sound command channel.
// Captures 68000 writes to the sound latch, presents the byte on `latch` and
// raises an NMI request pulse (`snreq`) toward the HuC6280 sound CPU.
// Build option JTCOP_SNDLATCH_FIFO_EN: queue commands in a 2**AW FIFO and
// hand them over one at a time, waiting for the sound CPU's latch-read
// acknowledge (or a timeout) between commands. Without it the block behaves
// like the original board: a single latch register with a retriggerable pulse.
module jtcop_sndlatch_tx #(
  parameter int SNREQ_LEN = 16,
  parameter int AW        = 2,
  parameter int ACK_TO    = 65535
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cpu_cs,
  input  logic       cpu_we,
  input  logic [7:0] cpu_dout,
  input  logic       snd_ack,
  output logic [7:0] latch,
  output logic       snreq,
  output logic       busy,
  output logic       drop
);

  localparam logic [7:0] CNT_INIT = 8'(SNREQ_LEN - 1);

  logic       r_wr_l;
  logic       w_wr;
  logic       w_wr_ev;
  logic [7:0] r_latch;
  logic       r_snreq;
  logic [7:0] r_cnt;

  // One event per bus cycle: only the rising edge of the qualified strobe counts
  assign w_wr    = cpu_cs & cpu_we;
  assign w_wr_ev = w_wr & ~r_wr_l;

  // Remember last strobe level for the write edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_l <= 1'b0;
    else     r_wr_l <= w_wr;
  end

  assign latch = r_latch;
  assign snreq = r_snreq;

`ifdef JTCOP_SNDLATCH_FIFO_EN

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
  localparam int TW    = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK} st_t;

  st_t             r_st;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_fcnt;
  logic [TW-1:0]   r_tmo;
  logic            r_ack_l;
  logic            r_drop;
  logic            w_ack_ev;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_tmo_hit;

  assign w_ack_ev  = snd_ack & ~r_ack_l;
  assign w_full    = (r_fcnt == CW'(DEPTH));
  assign w_push    = w_wr_ev & ~w_full;
  // A wait of ACK_TO cycles with no acknowledge discards the command
  assign w_tmo_hit = (ACK_TO != 0) && (r_tmo == TW'(ACK_TO - 1));
  assign w_pop     = (r_st == WAIT_ACK) & (w_ack_ev | w_tmo_hit);

  assign busy = (r_st != IDLE) | (r_fcnt != '0);
  assign drop = r_drop;

  // Acknowledge edge detector, ack only meaningful in WAIT_ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ack_l <= 1'b0;
    else     r_ack_l <= snd_ack;
  end

  // Command storage; contents are don't-care until pointers/count say otherwise
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= cpu_dout;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
      if (w_wr_ev & w_full) r_drop <= 1'b1;
    end
  end

  // Handover sequencer: load head, pulse snreq, then wait for ack or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= IDLE;
      r_latch <= 8'h00;
      r_snreq <= 1'b0;
      r_cnt   <= 8'h00;
      r_tmo   <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (r_fcnt != '0) begin
            r_latch <= r_mem[r_rp];
            r_snreq <= 1'b1;
            r_cnt   <= CNT_INIT;
            r_st    <= PULSE;
          end
        end
        PULSE: begin
          if (r_cnt == 8'h00) begin
            r_snreq <= 1'b0;
            r_tmo   <= '0;
            r_st    <= WAIT_ACK;
          end else begin
            r_cnt <= r_cnt - 8'h01;
          end
        end
        WAIT_ACK: begin
          // Returning through IDLE guarantees a >=2 cycle low gap on snreq
          if (w_pop) r_st  <= IDLE;
          else       r_tmo <= r_tmo + 1'b1;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

`else

  // The acknowledge has no role in the single-register build
  logic w_unused;
  assign w_unused = snd_ack;

  assign busy = r_snreq;
  assign drop = 1'b0;

  // Every write reloads the latch and (re)starts the pulse; no gap on retrigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= 8'h00;
      r_snreq <= 1'b0;
      r_cnt   <= 8'h00;
    end else if (w_wr_ev) begin
      r_latch <= cpu_dout;
      r_snreq <= 1'b1;
      r_cnt   <= CNT_INIT;
    end else if (r_snreq) begin
      if (r_cnt == 8'h00) r_snreq <= 1'b0;
      else                r_cnt   <= r_cnt - 8'h01;
    end
  end

`endif

endmodule

// File: tb/tb_jtcop_sndlatch_tx.sv
// Bench for jtcop_sndlatch_tx. Default build: per-cycle comparison against a
// timeline model (last write time + data) under directed and random writes.
// FIFO build: directed handover scenarios checked against a byte queue.
module tb_jtcop_sndlatch_tx;

  localparam int LEN = 16;
  localparam int AW  = 2;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_cs, cpu_we, snd_ack;
  logic [7:0] cpu_dout;
  logic [7:0] latch;
  logic       snreq, busy, drop;

  int errs   = 0;
  int checks = 0;

  jtcop_sndlatch_tx #(.SNREQ_LEN(LEN), .AW(AW), .ACK_TO(TO)) dut (
    .rst(rst), .clk(clk), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .snd_ack(snd_ack), .latch(latch), .snreq(snreq), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_dout = 8'h00; snd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_latch", {24'h0, latch}, 32'h0);
    chk("rst_snreq", {31'h0, snreq}, 32'h0);
    chk("rst_busy",  {31'h0, busy},  32'h0);
    chk("rst_drop",  {31'h0, drop},  32'h0);
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifndef JTCOP_SNDLATCH_FIFO_EN
  // Timeline model: snreq is high for LEN cycles after the most recent write
  // event; latch shows the byte of that write.
  int         cyc;
  int         m_last;
  logic       m_valid;
  logic       m_prev;
  logic [7:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_valid = 1'b0; m_prev = 1'b0; m_data = 8'h00; m_last = 0;
    end else begin
      cyc++;
      if (cpu_cs && cpu_we && !m_prev) begin
        m_last = cyc; m_data = cpu_dout; m_valid = 1'b1;
      end
      m_prev = cpu_cs & cpu_we;
    end
  end

  function automatic logic m_snreq();
    return m_valid && ((cyc - m_last) < LEN);
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, "_latch"}, {24'h0, latch}, {24'h0, m_data});
    chk({tag, "_snreq"}, {31'h0, snreq}, {31'h0, m_snreq()});
    chk({tag, "_busy"},  {31'h0, busy},  {31'h0, m_snreq()});
    chk({tag, "_drop"},  {31'h0, drop},  32'h0);
  endtask

  initial begin
    int run;
    do_reset();

    // Write 11 (long strobe), then 22 eight cycles later: pulse extends
    run = 0;
    for (int i = 0; i < 40; i++) begin
      cpu_cs   = (i < 3) || (i == 8) || (i == 9);
      cpu_we   = cpu_cs;
      cpu_dout = (i < 8) ? 8'h11 : 8'h22;
      @(negedge clk);
      if (i == 0) chk("first_latch", {24'h0, latch}, 32'h11);
      if (snreq) run++;
      cmp_model("retrig");
    end
    chk("retrig_run", run, 32'd24);
    chk("retrig_latch", {24'h0, latch}, 32'h22);

    // Random bus traffic, with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dout = 8'hA7;
        @(negedge clk);
        cmp_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_snreq", {31'h0, snreq}, 32'h0);
        chk("async_latch", {24'h0, latch}, 32'h0);
        cpu_cs = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
      cpu_cs   = ($urandom_range(0, 5) == 0);
      cpu_we   = ($urandom_range(0, 3) != 0);
      cpu_dout = 8'($urandom);
      snd_ack  = 1'($urandom);
      @(negedge clk);
      cmp_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

`else
  // FIFO build: directed handover scenarios
  logic [7:0] q[$];

  task automatic wr(input logic [7:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dout = d;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!snreq && n < 300) begin @(negedge clk); n++; end
    if (!snreq) chk("rise_timeout", 32'h0, 32'h1);
  endtask

  task automatic width(output int w);
    w = 0;
    while (snreq && w < 300) begin @(negedge clk); w++; end
  endtask

  task automatic ack();
    snd_ack = 1'b1;
    @(negedge clk);
    snd_ack = 1'b0;
  endtask

  initial begin
    int n, w;
    logic [7:0] d;
    do_reset();

    // Single command, held until acknowledged
    wr(8'h5A);
    wait_rise(n);
    chk("t1_latch", {24'h0, latch}, 32'h5A);
    width(w);
    chk("t1_width", w, LEN);
    repeat (5) @(negedge clk);
    chk("t1_busy_wait", {31'h0, busy}, 32'h1);
    ack();
    chk("t1_busy_done", {31'h0, busy}, 32'h0);
    chk("t1_latch_hold", {24'h0, latch}, 32'h5A);

    // Three back-to-back commands, issued one per acknowledge
    wr(8'h01); wr(8'h02); wr(8'h03);
    for (int k = 1; k <= 3; k++) begin
      wait_rise(n);
      if (k > 1) chk("t2_gap", n, 32'd1);
      chk("t2_latch", {24'h0, latch}, k);
      width(w);
      chk("t2_width", w, LEN);
      repeat (2) @(negedge clk);
      ack();
      chk("t2_low_after_ack", {31'h0, snreq}, 32'h0);
    end
    chk("t2_idle", {31'h0, busy}, 32'h0);

    // Overflow: five writes into a four-deep queue
    q.delete();
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      if (q.size() < (1 << AW)) q.push_back(d);
      wr(d);
    end
    chk("t3_drop", {31'h0, drop}, 32'h1);
    chk("t3_busy", {31'h0, busy}, 32'h1);
    d = q[$];
    while (q.size() > 0) begin
      wait_rise(n);
      chk("t3_latch", {24'h0, latch}, {24'h0, q.pop_front()});
      width(w);
      @(negedge clk);
      ack();
    end
    chk("t3_busy_done", {31'h0, busy}, 32'h0);
    chk("t3_latch_last", {24'h0, latch}, {24'h0, d});

    // Write arriving in the same cycle as the pop of the only entry
    do_reset();
    wr(8'hA1);
    wait_rise(n);
    width(w);
    snd_ack = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dout = 8'hB2;
    @(negedge clk);
    snd_ack = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    chk("t5_busy", {31'h0, busy}, 32'h1);
    chk("t5_snreq_low", {31'h0, snreq}, 32'h0);
    @(negedge clk);
    chk("t5_snreq_next", {31'h0, snreq}, 32'h1);
    chk("t5_latch", {24'h0, latch}, 32'hB2);
    width(w);
    ack();

    // Acknowledge never comes: timeout discards the command
    wr(8'h33);
    wait_rise(n);
    width(w);
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    chk("t4_timeout", n, TO);
    chk("t4_busy", {31'h0, busy}, 32'h0);
    chk("t4_latch", {24'h0, latch}, 32'h33);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
`endif

endmodule
